// File: rtl/linemult_seq.sv
// Mode-change sequencer for the line multiplier: commits linemult_sel at frame
// boundaries, pulses the PLL resets and blanks output. Option: LINEMULT_SEQ_WATCHDOG_EN.
module linemult_seq #(
    parameter int BLANK_CYC     = 16,
    parameter int PLL_RST_CYC   = 64,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int SETTLE_FRAMES = 2
) (
    input  logic       VCLK,
    input  logic       nVRST,
    input  logic       nVS_i,
    input  logic [1:0] mode_req,
    input  logic       pal_mode,
    input  logic [1:0] pll_locked,
    output logic [1:0] pll_areset,
    output logic [1:0] linemult_sel,
    output logic       nVRST_Tx_req,
    output logic       blank_o,
    output logic       busy,
    output logic       lock_err
);
    localparam int MAX_A = (BLANK_CYC > PLL_RST_CYC) ? BLANK_CYC : PLL_RST_CYC;
    localparam int MAX_C = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int CW    = $clog2(MAX_C + 1);
    localparam int FW    = $clog2(SETTLE_FRAMES + 1);

    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] RST_END   = CW'(PLL_RST_CYC - 1);
    localparam logic [CW-1:0] LOCK_END  = CW'(LOCK_TIMEOUT);
    localparam logic [FW-1:0] FRM_END   = FW'(SETTLE_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_VS, S_BLANK, S_PLL_RST,
        S_WAIT_LOCK, S_SETTLE, S_RELEASE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [FW-1:0] fcnt, fcnt_n;
    logic [1:0]    target, target_n;
    logic [1:0]    eff;
    logic [1:0]    sync1, sync2;
    logic          vs_d, vs_edge;
    logic          lock, lock_d;
    logic          from_idle, from_idle_n;
    logic          wd_trip;
    logic [1:0]    areset_nx, sel_nx;
    logic          tx_nx, blank_nx, busy_nx, err_nx;

    assign eff = (mode_req == 2'b11) ? 2'b00 :
                 (pal_mode && mode_req == 2'b10) ? 2'b01 : mode_req;
    assign vs_edge = vs_d & ~nVS_i;
    // target is 01 or 10 whenever lock matters; in IDLE it equals linemult_sel
    assign lock = target[1] ? sync2[1] : sync2[0];

`ifdef LINEMULT_SEQ_WATCHDOG_EN
    assign wd_trip = (linemult_sel != 2'b00) && !lock && !lock_d;
`else
    assign wd_trip = 1'b0;
`endif

    always_ff @(posedge VCLK or negedge nVRST) begin
        if (!nVRST) begin
            state        <= S_WAIT_VS;
            cnt          <= '0;
            fcnt         <= '0;
            target       <= 2'b00;
            from_idle    <= 1'b0;
            sync1        <= 2'b00;
            sync2        <= 2'b00;
            vs_d         <= 1'b0;
            lock_d       <= 1'b0;
            pll_areset   <= 2'b00;
            linemult_sel <= 2'b00;
            nVRST_Tx_req <= 1'b0;
            blank_o      <= 1'b1;
            busy         <= 1'b1;
            lock_err     <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            fcnt         <= fcnt_n;
            target       <= target_n;
            from_idle    <= from_idle_n;
            sync1        <= pll_locked;
            sync2        <= sync1;
            vs_d         <= nVS_i;
            lock_d       <= lock;
            pll_areset   <= areset_nx;
            linemult_sel <= sel_nx;
            nVRST_Tx_req <= tx_nx;
            blank_o      <= blank_nx;
            busy         <= busy_nx;
            lock_err     <= err_nx;
        end
    end

    always_comb begin
        state_n     = state;
        target_n    = target;
        from_idle_n = from_idle;
        case (state)
            S_IDLE: begin
                if (wd_trip) begin
                    state_n  = S_BLANK;
                    target_n = 2'b00;
                end else if (eff != linemult_sel) begin
                    state_n     = S_WAIT_VS;
                    from_idle_n = 1'b1;
                end
            end
            S_WAIT_VS: begin
                target_n = eff;
                if (from_idle && eff == linemult_sel)
                    state_n = S_IDLE;
                else if (vs_edge)
                    state_n = S_BLANK;
            end
            S_BLANK: begin
                if (cnt == BLANK_END)
                    state_n = (target == 2'b00) ? S_SETTLE : S_PLL_RST;
            end
            S_PLL_RST: begin
                if (cnt == RST_END)
                    state_n = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock && lock_d) begin
                    state_n = S_SETTLE;
                end else if (cnt == LOCK_END) begin
                    state_n  = S_SETTLE;
                    target_n = 2'b00;
                end
            end
            S_SETTLE: begin
                if (vs_edge && fcnt == FRM_END)
                    state_n = S_RELEASE;
            end
            S_RELEASE: state_n = S_IDLE;
            default:   state_n = S_WAIT_VS;
        endcase
    end

    // single shared counter: cleared on every state change, saturating
    always_comb begin
        if (state_n != state)
            cnt_n = '0;
        else if (cnt == '1)
            cnt_n = cnt;
        else
            cnt_n = cnt + CW'(1);

        if (state_n != state)
            fcnt_n = '0;
        else if (state == S_SETTLE && vs_edge && fcnt != '1)
            fcnt_n = fcnt + FW'(1);
        else
            fcnt_n = fcnt;
    end

    always_comb begin
        areset_nx = pll_areset;
        sel_nx    = linemult_sel;
        tx_nx     = nVRST_Tx_req;
        blank_nx  = blank_o;
        busy_nx   = busy;
        err_nx    = lock_err;
        if (state_n != state) begin
            case (state_n)
                S_IDLE: begin
                    tx_nx    = 1'b1;
                    blank_nx = 1'b0;
                    busy_nx  = 1'b0;
                end
                S_WAIT_VS: begin
                    busy_nx = 1'b1;
                    err_nx  = 1'b0;
                end
                S_BLANK: begin
                    blank_nx = 1'b1;
                    tx_nx    = 1'b0;
                    busy_nx  = 1'b1;
                    if (state == S_IDLE)
                        err_nx = 1'b1;
                end
                S_PLL_RST: begin
                    areset_nx = {target == 2'b10, target == 2'b01};
                end
                S_WAIT_LOCK: begin
                    areset_nx = 2'b00;
                end
                S_SETTLE: begin
                    sel_nx = target_n;
                    if (state == S_WAIT_LOCK && !(lock && lock_d))
                        err_nx = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
